// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state, next-PC source encoding and default vectors for pc_sequencer.
package pc_pkg;

    typedef enum logic {PC_IDLE, PC_RUN} pc_state_e;

    typedef enum logic [2:0] {SRC_TRAP, SRC_REDIR, SRC_HOLD, SRC_RAS, SRC_SEQ} pc_src_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_DEFAULT  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW:0]     count;

    assign top   = mem[ptr];
    assign empty = count == '0;
    assign full  = count == (PW+1)'(RAS_DEPTH);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr   <= '0;
            count <= '0;
        end else if (clear) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !pop) begin
            ptr   <= ptr + 1'b1;
            count <= full ? count : count + 1'b1;
        end else if (pop && !push) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Pop+push in one cycle rewrites the current top in place.
    always_ff @(posedge clk_i) begin
        if (push && !clear)
            mem[pop ? ptr : ptr + 1'b1] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with trap > redirect > stall > return > sequential priority.
// Define PC_RAS_EN to build the return-address stack; otherwise call_i/ret_i are ignored.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(PC_RESET_DEFAULT),
    parameter logic [XLEN-1:0] TRAP_PC     = XLEN'(PC_TRAP_DEFAULT),
    parameter int              INSTR_BYTES = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            trap_valid_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);
    pc_state_e       state;
    pc_src_e         src;
    logic [XLEN-1:0] pc_seq, pc_next, ras_top;
    logic            run, push, pop, clear;

    assign run    = state == PC_RUN && start_i;
    assign pc_seq = pc_o + XLEN'(INSTR_BYTES);

    always_comb begin
        src = trap_valid_i ? SRC_TRAP : redirect_valid_i ? SRC_REDIR : stall_i ? SRC_HOLD :
              (ret_i && !ras_empty_o) ? SRC_RAS : SRC_SEQ;
        pc_next = src == SRC_TRAP ? TRAP_PC : src == SRC_REDIR ? redirect_pc_i :
                  src == SRC_HOLD ? pc_o : src == SRC_RAS ? ras_top : pc_seq;
    end

    // A call records its return address on every advancing source except a trap.
    assign push  = run && call_i && (src == SRC_REDIR || src == SRC_RAS || src == SRC_SEQ);
    assign pop   = run && src == SRC_RAS;
    assign clear = !run || src == SRC_TRAP;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= PC_IDLE;
            pc_o       <= RESET_PC;
            pc_valid_o <= 1'b0;
        end else if (!start_i) begin
            state      <= PC_IDLE;
            pc_o       <= RESET_PC;
            pc_valid_o <= 1'b0;
        end else if (state == PC_IDLE) begin
            state      <= PC_RUN;
            pc_valid_o <= 1'b1;
        end else begin
            pc_o <= pc_next;
        end
    end

`ifdef PC_RAS_EN
    pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty_o),
        .full      (ras_full_o)
    );
`else
    logic unused_ras;
    assign unused_ras  = ^{push, pop, clear, RAS_DEPTH[0]};
    assign ras_top     = '0;
    assign ras_empty_o = 1'b1;
    assign ras_full_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus against a queue-based reference model.
module tb_pc_sequencer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_A = 32'h0;
    localparam logic [31:0] TRP_A = 32'h100;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        start_i = 1'b0, stall_i = 1'b0, trap_valid_i = 1'b0, redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        call_i = 1'b0, ret_i = 1'b0;
    logic [31:0] pc_o;
    logic        pc_valid_o, ras_empty_o, ras_full_o;

    int checks = 0, failures = 0;

    pc_sequencer #(.XLEN(32), .RAS_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .trap_valid_i(trap_valid_i), .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i(redirect_pc_i), .call_i(call_i), .ret_i(ret_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: running flag, PC value and a queue of return addresses (back = newest).
    bit          m_run = 1'b0, m_valid = 1'b0;
    logic [31:0] m_pc = RST_A;
    logic [31:0] m_ras[$];

    function automatic void m_push(input logic [31:0] a);
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(a);
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        logic [31:0] ra;
        if (!rst_i) begin
            m_run = 0; m_valid = 0; m_pc = RST_A; m_ras.delete();
        end else if (!start_i) begin
            m_run = 0; m_valid = 0; m_pc = RST_A; m_ras.delete();
        end else if (!m_run) begin
            m_run = 1; m_valid = 1;
        end else if (trap_valid_i) begin
            m_pc = TRP_A; m_ras.delete();
        end else begin
            ra = m_pc + 32'd4;
            if (redirect_valid_i) begin
                m_pc = redirect_pc_i;
                if (RAS_EN && call_i) m_push(ra);
            end else if (!stall_i) begin
                if (RAS_EN && ret_i && m_ras.size() > 0) m_pc = m_ras.pop_back();
                else m_pc = ra;
                if (RAS_EN && call_i) m_push(ra);
            end
        end
    end

    always @(negedge clk_i) begin
        check("cyc_pc", pc_o, m_pc);
        check("cyc_valid", 32'(pc_valid_o), 32'(m_valid));
        check("cyc_empty", 32'(ras_empty_o), 32'(m_ras.size() == 0));
        check("cyc_full", 32'(ras_full_o), 32'(m_ras.size() == DEPTH));
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        stall_i = 0; trap_valid_i = 0; redirect_valid_i = 0; call_i = 0; ret_i = 0;
    endtask

    initial begin
        #1;
        check("rst_pc", pc_o, RST_A);
        check("rst_valid", 32'(pc_valid_o), 32'd0);
        check("rst_empty", 32'(ras_empty_o), 32'd1);
        check("rst_full", 32'(ras_full_o), 32'd0);
        #1 rst_i = 1;
        step();
        check("idle_valid", 32'(pc_valid_o), 32'd0);
        start_i = 1;
        step(); check("start_pc0", pc_o, 32'h0); check("start_valid", 32'(pc_valid_o), 32'd1);
        step(); check("seq_4", pc_o, 32'h4);
        step(); check("seq_8", pc_o, 32'h8);
        step(); check("seq_c", pc_o, 32'hc);
        redirect_valid_i = 1; redirect_pc_i = 32'h20;
        step(); check("redir_20", pc_o, 32'h20);
        quiet(); stall_i = 1;
        step(); check("stall_1", pc_o, 32'h20);
        step(); check("stall_2", pc_o, 32'h20);
        stall_i = 0;
        step(); check("resume_24", pc_o, 32'h24);
        stall_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h80;
        step(); check("stall_redir", pc_o, 32'h80);
        quiet();
`ifdef PC_RAS_EN
        redirect_valid_i = 1; redirect_pc_i = 32'h10;
        step(); check("to_10", pc_o, 32'h10);
        call_i = 1; redirect_pc_i = 32'h200;
        step(); check("call_200", pc_o, 32'h200); check("call_nonempty", 32'(ras_empty_o), 32'd0);
        quiet(); step(); step(); check("at_208", pc_o, 32'h208);
        ret_i = 1;
        step(); check("ret_14", pc_o, 32'h14); check("ret_empty", 32'(ras_empty_o), 32'd1);
        quiet(); call_i = 1;
        repeat (5) step();
        check("five_full", 32'(ras_full_o), 32'd1); check("five_pc", pc_o, 32'h28);
        quiet(); ret_i = 1;
        step(); check("ret_a", pc_o, 32'h28);
        step(); check("ret_b", pc_o, 32'h24);
        step(); check("ret_c", pc_o, 32'h20);
        step(); check("ret_d", pc_o, 32'h1c); check("ret_drained", 32'(ras_empty_o), 32'd1);
        quiet(); call_i = 1;
        step(); check("pre_trap_push", 32'(ras_empty_o), 32'd0);
`else
        call_i = 1; ret_i = 1;
        step(); check("noras_seq", pc_o, 32'h84); check("noras_empty", 32'(ras_empty_o), 32'd1);
`endif
        quiet(); trap_valid_i = 1; redirect_valid_i = 1; stall_i = 1; ret_i = 1;
        redirect_pc_i = 32'h300;
        step(); check("trap_pc", pc_o, TRP_A); check("trap_empty", 32'(ras_empty_o), 32'd1);
        quiet(); redirect_valid_i = 1; redirect_pc_i = 32'hffff_fffc;
        step(); check("top_addr", pc_o, 32'hffff_fffc);
        quiet();
        step(); check("wrap_0", pc_o, 32'h0);
        start_i = 0;
        step(); check("drop_pc", pc_o, RST_A); check("drop_valid", 32'(pc_valid_o), 32'd0);
        for (int i = 0; i < 3000; i++) begin
            start_i          = $urandom_range(0, 24) != 0;
            stall_i          = $urandom_range(0, 3) == 0;
            trap_valid_i     = $urandom_range(0, 49) == 0;
            redirect_valid_i = $urandom_range(0, 7) == 0;
            redirect_pc_i    = $urandom_range(0, 15) == 0 ? 32'hffff_fff8 : 32'($urandom_range(0, 1023)) << 2;
            call_i           = $urandom_range(0, 3) == 0;
            ret_i            = $urandom_range(0, 3) == 0;
            step();
        end
        quiet(); start_i = 0;
        step();
        start_i = 1;
        step();
        redirect_valid_i = 1; redirect_pc_i = 32'h38; call_i = 1;
        step();
        redirect_valid_i = 0;
        step();
        call_i = 0;
        step(); check("pre_rst_pc", pc_o, 32'h40);
        check("pre_rst_empty", 32'(ras_empty_o), RAS_EN ? 32'd0 : 32'd1);
        #2 rst_i = 0;
        #1;
        check("async_pc", pc_o, RST_A);
        check("async_valid", 32'(pc_valid_o), 32'd0);
        check("async_empty", 32'(ras_empty_o), 32'd1);
        step(); step();
        rst_i = 1;
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
